// File: rtl/div_issue_queue.sv
// div_issue_queue: signed front-end for an iterative unsigned divider.
//
// Buffers signed dividend/divisor pairs in a DEPTH-entry FIFO. Issues one
// operation at a time to the divider as unsigned magnitudes. Applies
// truncating-division sign correction to the returned quotient and remainder.
// Presents the result downstream under valid/ready.
//
// Optional feature: define DIV_ISSUE_QUEUE_OVF_DETECT_EN to flag the
// -2^(WIDTH-1) / -1 quotient overflow. In that case error_out=1 and the
// quotient saturates to 2^(WIDTH-1)-1. Without the macro the quotient wraps.
//
// Ports:
//   clk_in, rst_in                 clock, async active-low reset
//   dividend_in, divisor_in        signed request operands
//   valid_in / ready_out           request handshake (ready_out = not full)
//   count_out                      FIFO occupancy
//   div_dividend_out, div_divisor_out, div_valid_out
//                                  magnitudes plus a one-cycle issue strobe
//   div_busy_in                    divider busy
//   div_quotient_in, div_remainder_in, div_error_in, div_valid_in
//                                  divider result
//   quotient_out, remainder_out, error_out, valid_out / ready_in
//                                  signed result handshake
module div_issue_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [WIDTH-1:0]             dividend_in,
    input  logic [WIDTH-1:0]             divisor_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    output logic [$clog2(DEPTH+1)-1:0]   count_out,
    output logic [WIDTH-1:0]             div_dividend_out,
    output logic [WIDTH-1:0]             div_divisor_out,
    output logic                         div_valid_out,
    input  logic                         div_busy_in,
    input  logic [WIDTH-1:0]             div_quotient_in,
    input  logic [WIDTH-1:0]             div_remainder_in,
    input  logic                         div_error_in,
    input  logic                         div_valid_in,
    output logic [WIDTH-1:0]             quotient_out,
    output logic [WIDTH-1:0]             remainder_out,
    output logic                         error_out,
    output logic                         valid_out,
    input  logic                         ready_in
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [WIDTH-1:0] dvd_mem [DEPTH];
    logic [WIDTH-1:0] dvs_mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic             dsign_q, qsign_q;
    logic [WIDTH-1:0] head_dvd, head_dvs;
    logic             push, pop, load_result;
    logic [WIDTH-1:0] q_next, r_next;
    logic             err_next;
`ifdef DIV_ISSUE_QUEUE_OVF_DETECT_EN
    logic             ovf_q;
`endif

    // Two's complement magnitude; the most-negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    assign ready_out     = (count_q < FULL_COUNT);
    assign count_out     = count_q;
    assign div_valid_out = (state_q == S_ISSUE);
    assign head_dvd      = dvd_mem[rptr_q];
    assign head_dvs      = dvs_mem[rptr_q];
    assign push          = valid_in && ready_out;
    assign pop           = (state_q == S_IDLE) && (count_q != '0) && !div_busy_in;
    assign load_result   = (state_q == S_WAIT) && div_valid_in;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pop) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (div_valid_in) state_d = S_HOLD;
            S_HOLD:  if (ready_in) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        q_next   = qsign_q ? -div_quotient_in : div_quotient_in;
        r_next   = dsign_q ? -div_remainder_in : div_remainder_in;
        err_next = 1'b0;
        if (div_error_in) begin
            q_next   = '0;
            r_next   = '0;
            err_next = 1'b1;
        end
`ifdef DIV_ISSUE_QUEUE_OVF_DETECT_EN
        else if (ovf_q) begin
            q_next   = {1'b0, {(WIDTH-1){1'b1}}};
            r_next   = '0;
            err_next = 1'b1;
        end
`endif
    end

    // Storage is not reset; count/pointers alone define which entries are live.
    always_ff @(posedge clk_in) begin
        if (push) begin
            dvd_mem[wptr_q] <= dividend_in;
            dvs_mem[wptr_q] <= divisor_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wptr_q           <= '0;
            rptr_q           <= '0;
            count_q          <= '0;
            state_q          <= S_IDLE;
            dsign_q          <= 1'b0;
            qsign_q          <= 1'b0;
            div_dividend_out <= '0;
            div_divisor_out  <= '0;
            quotient_out     <= '0;
            remainder_out    <= '0;
            error_out        <= 1'b0;
            valid_out        <= 1'b0;
`ifdef DIV_ISSUE_QUEUE_OVF_DETECT_EN
            ovf_q            <= 1'b0;
`endif
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop) begin
                rptr_q           <= rptr_q + AW'(1);
                div_dividend_out <= mag(head_dvd);
                div_divisor_out  <= mag(head_dvs);
                dsign_q          <= head_dvd[WIDTH-1];
                qsign_q          <= head_dvd[WIDTH-1] ^ head_dvs[WIDTH-1];
`ifdef DIV_ISSUE_QUEUE_OVF_DETECT_EN
                ovf_q <= (head_dvd == {1'b1, {(WIDTH-1){1'b0}}}) && (head_dvs == '1);
`endif
            end
            if (load_result) begin
                quotient_out  <= q_next;
                remainder_out <= r_next;
                error_out     <= err_next;
                valid_out     <= 1'b1;
            end else if ((state_q == S_HOLD) && ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_issue_queue.sv
module tb_div_issue_queue;
    localparam int W = 8;
    localparam int D = 4;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic [W-1:0] dividend_in = '0, divisor_in = '0;
    logic         valid_in = 1'b0;
    logic         ready_out;
    logic [2:0]   count_out;
    logic [W-1:0] div_dividend_out, div_divisor_out;
    logic         div_valid_out;
    logic         div_busy_in;
    logic [W-1:0] div_quotient_in, div_remainder_in;
    logic         div_error_in;
    logic         div_valid_in;
    logic [W-1:0] quotient_out, remainder_out;
    logic         error_out, valid_out;
    logic         ready_in = 1'b0;

    logic         mdl_valid;
    logic         late_valid = 1'b0;
    logic [W-1:0] mdl_a, mdl_b;
    int           mdl_cnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk_in = ~clk_in;

    div_issue_queue #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .dividend_in(dividend_in), .divisor_in(divisor_in),
        .valid_in(valid_in), .ready_out(ready_out), .count_out(count_out),
        .div_dividend_out(div_dividend_out), .div_divisor_out(div_divisor_out),
        .div_valid_out(div_valid_out), .div_busy_in(div_busy_in),
        .div_quotient_in(div_quotient_in), .div_remainder_in(div_remainder_in),
        .div_error_in(div_error_in), .div_valid_in(div_valid_in),
        .quotient_out(quotient_out), .remainder_out(remainder_out),
        .error_out(error_out), .valid_out(valid_out), .ready_in(ready_in)
    );

    // Divider model: answers 3 cycles after the issue strobe. On a zero
    // divisor it returns junk quotient/remainder with the error flag set.
    assign div_valid_in = mdl_valid | late_valid;

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mdl_cnt          <= 0;
            mdl_valid        <= 1'b0;
            div_busy_in      <= 1'b0;
            div_quotient_in  <= '0;
            div_remainder_in <= '0;
            div_error_in     <= 1'b0;
            mdl_a            <= '0;
            mdl_b            <= '0;
        end else begin
            mdl_valid <= 1'b0;
            if (div_valid_out) begin
                mdl_a       <= div_dividend_out;
                mdl_b       <= div_divisor_out;
                mdl_cnt     <= 3;
                div_busy_in <= 1'b1;
            end else if (mdl_cnt != 0) begin
                mdl_cnt <= mdl_cnt - 1;
                if (mdl_cnt == 1) begin
                    mdl_valid   <= 1'b1;
                    div_busy_in <= 1'b0;
                    if (mdl_b == 0) begin
                        div_quotient_in  <= 8'hFF;
                        div_remainder_in <= mdl_a;
                        div_error_in     <= 1'b1;
                    end else begin
                        div_quotient_in  <= mdl_a / mdl_b;
                        div_remainder_in <= mdl_a % mdl_b;
                        div_error_in     <= 1'b0;
                    end
                end
            end
        end
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
    } vec_t;

    vec_t vecs [12];
    vec_t bp [6];

    task automatic check(input string name, input int tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [%0d]: got %0h, expected %0h", name, tag, act, exp);
    endtask

    function automatic logic [W-1:0] tb_mag(input logic [W-1:0] x);
        logic [W-1:0] z;
        z = 8'd0 - x;
        return x[W-1] ? z : x;
    endfunction

    task automatic run_one(input int idx, input vec_t v);
        bit found;
        @(negedge clk_in);
        dividend_in = v.a;
        divisor_in  = v.b;
        valid_in    = 1'b1;
        @(posedge clk_in);
        #1 valid_in = 1'b0;
        @(negedge clk_in);
        check("issue_early", idx, div_valid_out, 0);
        @(negedge clk_in);
        check("issue_n2", idx, div_valid_out, 1);
        check("div_dividend", idx, div_dividend_out, tb_mag(v.a));
        check("div_divisor", idx, div_divisor_out, tb_mag(v.b));
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk_in);
            if (div_valid_in) found = 1'b1;
        end
        check("div_resp_seen", idx, found, 1);
        @(negedge clk_in);
        check("valid_m1", idx, valid_out, 1);
        repeat (2) @(negedge clk_in);
        check("valid_hold", idx, valid_out, 1);
        check("quotient", idx, quotient_out, v.q);
        check("remainder", idx, remainder_out, v.r);
        check("error", idx, error_out, v.e);
        ready_in = 1'b1;
        @(posedge clk_in);
        #1 ready_in = 1'b0;
        @(negedge clk_in);
        check("valid_drop", idx, valid_out, 0);
    endtask

    task automatic check_reset_values(input int tag);
        check("rst_count", tag, count_out, 0);
        check("rst_ready", tag, ready_out, 1);
        check("rst_div_valid", tag, div_valid_out, 0);
        check("rst_div_dvd", tag, div_dividend_out, 0);
        check("rst_div_dvs", tag, div_divisor_out, 0);
        check("rst_q", tag, quotient_out, 0);
        check("rst_r", tag, remainder_out, 0);
        check("rst_err", tag, error_out, 0);
        check("rst_valid", tag, valid_out, 0);
    endtask

    initial begin
        bit found;
        bit seen;
        vecs[0]  = '{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0};  // -7/2
        vecs[1]  = '{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0};  // 7/-2
        vecs[2]  = '{8'hF9, 8'hFE, 8'h03, 8'hFF, 1'b0};  // -7/-2
        vecs[3]  = '{8'h07, 8'h02, 8'h03, 8'h01, 1'b0};  // 7/2
        vecs[4]  = '{8'h05, 8'h00, 8'h00, 8'h00, 1'b1};  // 5/0
`ifdef DIV_ISSUE_QUEUE_OVF_DETECT_EN
        vecs[5]  = '{8'h80, 8'hFF, 8'h7F, 8'h00, 1'b1};  // -128/-1 saturates
`else
        vecs[5]  = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0};  // -128/-1 wraps
`endif
        vecs[6]  = '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0};  // -128/1
        vecs[7]  = '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0};  // 100/7
        vecs[8]  = '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0};  // -100/7
        vecs[9]  = '{8'h00, 8'h05, 8'h00, 8'h00, 1'b0};  // 0/5
        vecs[10] = '{8'h80, 8'h03, 8'hD6, 8'hFE, 1'b0};  // -128/3
        vecs[11] = '{8'hFF, 8'h80, 8'h00, 8'hFF, 1'b0};  // -1/-128

        bp[0] = '{8'h14, 8'h03, 8'h06, 8'h02, 1'b0};     // 20/3
        bp[1] = '{8'hEC, 8'h03, 8'hFA, 8'hFE, 1'b0};     // -20/3
        bp[2] = '{8'h14, 8'hFD, 8'hFA, 8'h02, 1'b0};     // 20/-3
        bp[3] = '{8'hEC, 8'hFD, 8'h06, 8'hFE, 1'b0};     // -20/-3
        bp[4] = '{8'h09, 8'h09, 8'h01, 8'h00, 1'b0};     // 9/9
        bp[5] = '{8'h01, 8'h01, 8'h01, 8'h00, 1'b0};     // dropped

        #2 rst_in = 1'b0;
        #1 check_reset_values(0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        check_reset_values(1);

        for (int i = 0; i < 12; i++) run_one(i, vecs[i]);

        // Back-pressure: 6 back-to-back pushes, first issues, FIFO fills to 4.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            dividend_in = bp[i].a;
            divisor_in  = bp[i].b;
            valid_in    = 1'b1;
        end
        @(negedge clk_in);
        valid_in = 1'b0;
        check("bp_count_full", 0, count_out, 4);
        check("bp_ready_low", 0, ready_out, 0);
        ready_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            for (int c = 0; c < 30 && !found; c++) begin
                @(negedge clk_in);
                if (valid_out) found = 1'b1;
            end
            check("bp_result_seen", k, found, 1);
            check("bp_quotient", k, quotient_out, bp[k].q);
            check("bp_remainder", k, remainder_out, bp[k].r);
            @(posedge clk_in);
        end
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_in);
            if (valid_out) seen = 1'b1;
        end
        check("bp_no_sixth", 0, seen, 0);
        check("bp_count_empty", 0, count_out, 0);
        ready_in = 1'b0;

        // Reset while in WAIT with two entries queued.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            dividend_in = 8'd50 + 8'(i * 10);
            divisor_in  = 8'd5;
            valid_in    = 1'b1;
        end
        @(negedge clk_in);
        valid_in = 1'b0;
        check("mid_count_before", 0, count_out, 2);
        rst_in = 1'b0;
        #1 check_reset_values(2);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        late_valid = 1'b1;
        @(negedge clk_in);
        late_valid = 1'b0;
        seen = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_in);
            if (valid_out) seen = 1'b1;
            if (div_valid_out) found = 1'b1;
        end
        check("late_valid_ignored", 0, seen, 0);
        check("no_issue_after_rst", 0, found, 0);
        check("mid_count_after", 0, count_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end
endmodule

// File: doc/div_issue_queue.md
# div_issue_queue

Signed request front-end for the iterative unsigned divider. Buffers signed dividend/divisor pairs in a FIFO and converts each to magnitudes. Issues one operation at a time to the divider when it is idle, then applies sign correction to the returned quotient/remainder. Presents each result downstream under a valid/ready handshake.

## Interface
- WIDTH, 32, operand/result width (two's complement)
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk_in  input  1  clock; all logic on rising edge
- rst_in  input  1  reset, asynchronous, active-low
- dividend_in  input  WIDTH  signed dividend
- divisor_in  input  WIDTH  signed divisor
- valid_in  input  1  upstream request valid
- ready_out  output  1  FIFO can accept (count < DEPTH)
- count_out  output  $clog2(DEPTH+1)  FIFO occupancy
- div_dividend_out  output  WIDTH  unsigned magnitude to divider
- div_divisor_out  output  WIDTH  unsigned magnitude to divider
- div_valid_out  output  1  one-cycle issue strobe to divider
- div_busy_in  input  1  divider busy
- div_quotient_in  input  WIDTH  unsigned quotient from divider
- div_remainder_in  input  WIDTH  unsigned remainder from divider
- div_error_in  input  1  divider divide-by-zero flag
- div_valid_in  input  1  divider result strobe
- quotient_out  output  WIDTH  signed quotient
- remainder_out  output  WIDTH  signed remainder
- error_out  output  1  result is an error
- valid_out  output  1  result valid, held until accepted
- ready_in  input  1  downstream accepts result

## Operation
- Push: valid_in && ready_out writes {dividend_in, divisor_in} at the tail. When full, valid_in is ignored and nothing is written.
- Push and pop in the same cycle leave count_out unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE → ISSUE when count_out > 0 and !div_busy_in. Pops the head; latches magnitudes into div_*_out, plus the dividend sign and the quotient sign (dividend sign XOR divisor sign).
  - ISSUE: div_valid_out = 1 for exactly this cycle. → WAIT.
  - WAIT: div_valid_in is sampled here only, then → HOLD. Result registers load on that edge:
    - quotient_out = the quotient negated if the quotient sign is set.
    - remainder_out = the remainder negated if the dividend sign is set (truncating division).
    - error_out = div_error_in.
    - valid_out = 1.
  - div_error_in = 1 forces quotient_out = 0 and remainder_out = 0.
  - HOLD: outputs are stable while ready_in = 0. valid_out && ready_in → IDLE, valid_out = 0.
- div_valid_in outside WAIT is ignored.
- Magnitude: abs(x) = x[WIDTH-1] ? -x : x, interpreted unsigned. The most-negative value maps to 2^(WIDTH-1), which is representable.
- Negation is two's complement modulo 2^WIDTH.
- At most one operation is in flight. FIFO pushes continue in every state.

## Timing
- Reset (asynchronous assert, synchronous deassert) clears:
  - state = IDLE
  - pointers and count_out = 0
  - ready_out = 1
  - div_valid_out = 0, div_dividend_out = 0, div_divisor_out = 0
  - quotient_out = 0, remainder_out = 0, error_out = 0, valid_out = 0
- Reset mid-operation discards the FIFO contents and any in-flight result.
- Push at edge N → earliest div_valid_out high in cycle N+2 (IDLE sees the entry at N+1).
- div_valid_in high in cycle M → valid_out high from cycle M+1.
- After acceptance at edge K, IDLE at K+1. The next div_valid_out comes no earlier than K+2.
- ready_out and count_out are registered-state derived; no combinational path from valid_in.

## Configuration
- DIV_ISSUE_QUEUE_OVF_DETECT_EN defined:
  - The quotient-overflow case (dividend = -2^(WIDTH-1) with divisor = -1, and no divider error) sets error_out = 1.
  - In that case quotient_out saturates to 2^(WIDTH-1)-1 and remainder_out = 0.
- Not defined: the quotient wraps to -2^(WIDTH-1), remainder_out = 0, error_out = 0.

## Test plan
- WIDTH=8, one request, divider model returns after 3 cycles:
  - push -7/2 → div operands 7/2; q=-3, r=-1, error_out=0.
  - push 7/-2 → q=-3, r=1.
- Push 5/0 with the divider model asserting div_error_in → valid_out=1, error_out=1, q=0, r=0.
- Push -128/-1:
  - macro defined → error_out=1, q=127, r=0.
  - macro undefined → error_out=0, q=-128 (0x80), r=0.
- DEPTH=4, ready_in=0, push 6 requests back-to-back:
  - First is issued; count_out reaches 4; ready_out=0; the 6th is dropped.
  - After ready_in=1, the 5 results emerge in order with no reordering.
- Assert rst_in=0 during WAIT with 2 entries queued:
  - All outputs take their reset values immediately; count_out=0.
  - A late div_valid_in after reset is ignored.
